// File: rtl/pipe_pkg.sv
// Shared definitions for the core's pipeline registers (IF/ID and its ID/EX, EX/MEM successors).
package pipe_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } pipe_state_e;

    // addi x0,x0,0
    localparam logic [31:0] RV_NOP = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } pipe_entry_t;

    function automatic pipe_entry_t pipe_bubble();
        pipe_entry_t e;
        e.pc    = '0;
        e.instr = RV_NOP;
        return e;
    endfunction

endpackage

// File: rtl/ifid_pipe_stage_if.sv
// Fetch-to-decode bus of the IF/ID stage; names are seen from the stage's side.
interface ifid_pipe_stage_if #(
    parameter int PC_W    = 32,
    parameter int INSTR_W = 32
);
    // A word moves when valid and ready are both high at a rising clock edge;
    // a producer keeps valid and its data stable until that happens, and
    // ready may depend on valid but valid never depends on ready.
    logic               flush_i;
    logic               valid_i;
    logic               ready_o;
    logic [PC_W-1:0]    PC_i;
    logic [INSTR_W-1:0] instruc_i;
    logic               valid_o;
    logic               ready_i;
    logic [PC_W-1:0]    PC_o;
    logic [INSTR_W-1:0] instruc_o;
    logic [1:0]         occ_o;

    modport master (
        output flush_i, valid_i, PC_i, instruc_i, ready_i,
        input  ready_o, valid_o, PC_o, instruc_o, occ_o
    );

    modport slave (
        input  flush_i, valid_i, PC_i, instruc_i, ready_i,
        output ready_o, valid_o, PC_o, instruc_o, occ_o
    );

endinterface

// File: rtl/ifid_pipe_stage.sv
// IF/ID pipeline register: PC and instruction from fetch to decode, with an optional
// skid entry so ready_o is purely registered, and a flush that squashes both entries.
module ifid_pipe_stage
    import pipe_pkg::*;
#(
    parameter int          PC_W      = 32,
    parameter int          INSTR_W   = 32,
    parameter bit          SKID_EN   = 1'b1,
    parameter logic [31:0] NOP_INSTR = RV_NOP
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    ifid_pipe_stage_if.slave bus,
    output pipe_state_e state_o
);

    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } entry_t;

    localparam logic [INSTR_W-1:0] NOP_W  = INSTR_W'(NOP_INSTR);
    localparam entry_t             BUBBLE = '{pc: '0, instr: NOP_W};

    pipe_state_e state_q, state_d;
    entry_t      main_q, main_d;
    entry_t      skid_q, skid_d;
    entry_t      in_entry;
    logic        valid_int;
    logic        ready_int;
    logic        in_fire;
    logic        out_fire;

    assign in_entry  = '{pc: bus.PC_i, instr: bus.instruc_i};
    assign valid_int = (state_q != ST_EMPTY);
    assign in_fire   = bus.valid_i && ready_int;
    assign out_fire  = valid_int && bus.ready_i;

    generate
        if (SKID_EN) begin : g_skid
            // ready_o comes from state only, breaking the ready path back into fetch
            assign ready_int = rst_n_i && (state_q != ST_SKID);

            always_ff @(posedge clk_i or negedge rst_n_i) begin
                if (!rst_n_i) skid_q <= BUBBLE;
                else          skid_q <= skid_d;
            end
        end else begin : g_no_skid
            assign ready_int = rst_n_i && (!valid_int || bus.ready_i);
            assign skid_q    = BUBBLE;
        end
    endgenerate

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= ST_EMPTY;
            main_q  <= BUBBLE;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
        end
    end

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        // A flushed cycle still lets decode consume the head; it just leaves nothing behind.
        if (bus.flush_i) begin
            state_d = ST_EMPTY;
            main_d  = BUBBLE;
            skid_d  = BUBBLE;
        end else begin
            unique case (state_q)
                ST_EMPTY: begin
                    if (in_fire) begin
                        state_d = ST_FULL;
                        main_d  = in_entry;
                    end
                end
                ST_FULL: begin
                    if (in_fire && out_fire) begin
                        main_d = in_entry;
                    end else if (in_fire && SKID_EN) begin
                        state_d = ST_SKID;
                        skid_d  = in_entry;
                    end else if (out_fire) begin
                        state_d = ST_EMPTY;
                        main_d  = BUBBLE;
                    end
                end
                ST_SKID: begin
                    if (out_fire) begin
                        state_d = ST_FULL;
                        main_d  = skid_q;
                        skid_d  = BUBBLE;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                    main_d  = BUBBLE;
                    skid_d  = BUBBLE;
                end
            endcase
        end
    end

    assign bus.ready_o   = ready_int;
    assign bus.valid_o   = valid_int;
    assign bus.PC_o      = main_q.pc;
    assign bus.instruc_o = main_q.instr;
    assign bus.occ_o     = state_q;
    assign state_o       = state_q;

endmodule

// File: tb/tb_ifid_pipe_stage.sv
// Bench for ifid_pipe_stage: both SKID_EN variants share one stimulus stream and are
// tracked by a queue model; directed tables and sequences cover the corner cases.
module tb_ifid_pipe_stage;
    import pipe_pkg::*;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        valid_i = 1'b0;
    logic        ready_i = 1'b1;
    logic        flush_i = 1'b0;
    logic [31:0] pc_i = '0;
    logic [31:0] instr_i = '0;

    int n_checks = 0;
    int n_fail   = 0;

    logic [63:0] exp_q1[$];
    logic [63:0] exp_q0[$];

    pipe_state_e st1, st0;

    ifid_pipe_stage_if #(.PC_W(32), .INSTR_W(32)) if1 ();
    ifid_pipe_stage_if #(.PC_W(32), .INSTR_W(32)) if0 ();

    assign if1.valid_i = valid_i;   assign if0.valid_i = valid_i;
    assign if1.ready_i = ready_i;   assign if0.ready_i = ready_i;
    assign if1.flush_i = flush_i;   assign if0.flush_i = flush_i;
    assign if1.PC_i = pc_i;         assign if0.PC_i = pc_i;
    assign if1.instruc_i = instr_i; assign if0.instruc_i = instr_i;

    ifid_pipe_stage #(.PC_W(32), .INSTR_W(32), .SKID_EN(1'b1), .NOP_INSTR(NOP)) dut1 (
        .clk_i(clk), .rst_n_i(rst_n), .bus(if1.slave), .state_o(st1));
    ifid_pipe_stage #(.PC_W(32), .INSTR_W(32), .SKID_EN(1'b0), .NOP_INSTR(NOP)) dut0 (
        .clk_i(clk), .rst_n_i(rst_n), .bus(if0.slave), .state_o(st0));

    always #5 clk = ~clk;

    function automatic logic [31:0] instr_of(input logic [31:0] pc);
        return pc ^ 32'hDEAD_0000;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    task automatic check_dut(input string tag, input bit skid, input int sz, input logic [63:0] head,
                             input logic v, input logic [31:0] pc, input logic [31:0] ins,
                             input logic [1:0] occ, input logic rdy, input logic [1:0] st);
        logic e_rdy;
        e_rdy = rst_n && (skid ? (sz < 2) : (sz == 0 || ready_i));
        chk({tag, ".valid_o"}, 64'(v), 64'(sz > 0));
        chk({tag, ".PC_o"}, 64'(pc), (sz > 0) ? 64'(head[63:32]) : 64'h0);
        chk({tag, ".instruc_o"}, 64'(ins), (sz > 0) ? 64'(head[31:0]) : 64'(NOP));
        chk({tag, ".occ_o"}, 64'(occ), 64'(sz));
        chk({tag, ".state_o"}, 64'(st), 64'(sz));
        chk({tag, ".ready_o"}, 64'(rdy), 64'(e_rdy));
    endtask

    always @(negedge clk) begin
        check_dut("skid1", 1'b1, exp_q1.size(), (exp_q1.size() > 0) ? exp_q1[0] : 64'h0,
                  if1.valid_o, if1.PC_o, if1.instruc_o, if1.occ_o, if1.ready_o, st1);
        check_dut("skid0", 1'b0, exp_q0.size(), (exp_q0.size() > 0) ? exp_q0[0] : 64'h0,
                  if0.valid_o, if0.PC_o, if0.instruc_o, if0.occ_o, if0.ready_o, st0);
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_q1.delete();
            exp_q0.delete();
        end else begin
            automatic int  s1 = exp_q1.size();
            automatic int  s0 = exp_q0.size();
            automatic bit  in1 = valid_i && (s1 < 2);
            automatic bit  in0 = valid_i && (s0 == 0 || ready_i);
            if (flush_i) begin
                exp_q1.delete();
                exp_q0.delete();
            end else begin
                if (s1 > 0 && ready_i) void'(exp_q1.pop_front());
                if (in1) exp_q1.push_back({pc_i, instr_i});
                if (s0 > 0 && ready_i) void'(exp_q0.pop_front());
                if (in0) exp_q0.push_back({pc_i, instr_i});
            end
        end
    end

    // ---------------- driver ----------------
    task automatic step(input logic v, input logic r, input logic f, input logic [31:0] pc);
        @(posedge clk);
        #1;
        valid_i = v;
        ready_i = r;
        flush_i = f;
        pc_i    = pc;
        instr_i = instr_of(pc);
    endtask

    typedef struct {
        logic        v, r, f;
        logic [31:0] pc;
        logic        e_valid;
        logic [31:0] e_pc;
        logic [1:0]  e_occ;
        logic        e_ready;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic v, input logic r, input logic f, input logic [31:0] pc,
                       input logic ev, input logic [31:0] epc, input logic [1:0] eocc, input logic erdy);
        tbl.push_back('{v: v, r: r, f: f, pc: pc, e_valid: ev, e_pc: epc, e_occ: eocc, e_ready: erdy});
    endtask

    initial begin
        // streaming 0x100..0x11C
        add(1, 1, 0, 32'h100, 0, 32'h0, 0, 1);
        for (int k = 1; k < 8; k++) add(1, 1, 0, 32'h100 + 4 * k, 1, 32'h100 + 4 * (k - 1), 1, 1);
        add(0, 1, 0, 32'h0, 1, 32'h11C, 1, 1);
        add(0, 0, 0, 32'h0, 0, 32'h0, 0, 1);
        // stall absorb into the skid entry, then drain in order
        add(1, 0, 0, 32'h200, 0, 32'h0, 0, 1);
        add(1, 0, 0, 32'h204, 1, 32'h200, 1, 1);
        add(1, 0, 0, 32'h208, 1, 32'h200, 2, 0);
        add(0, 1, 0, 32'h0, 1, 32'h200, 2, 0);
        add(0, 1, 0, 32'h0, 1, 32'h204, 1, 1);
        add(0, 1, 0, 32'h0, 0, 32'h0, 0, 1);
        // flush while two entries are held and 0x300 is offered
        add(1, 0, 0, 32'h280, 0, 32'h0, 0, 1);
        add(1, 0, 0, 32'h284, 1, 32'h280, 1, 1);
        add(1, 0, 1, 32'h300, 1, 32'h280, 2, 0);
        add(0, 1, 0, 32'h0, 0, 32'h0, 0, 1);
        // flush with a same-cycle accepted input: input discarded, head consumed
        add(1, 1, 0, 32'h400, 0, 32'h0, 0, 1);
        add(1, 1, 1, 32'h404, 1, 32'h400, 1, 1);
        add(0, 1, 0, 32'h0, 0, 32'h0, 0, 1);

        // reset held with random inputs
        repeat (4) begin
            @(posedge clk);
            #1;
            valid_i = 1'($urandom_range(0, 1));
            ready_i = 1'($urandom_range(0, 1));
            flush_i = 1'($urandom_range(0, 1));
            pc_i    = $urandom();
            instr_i = $urandom();
        end
        @(negedge clk);
        chk("reset.ready_o", 64'(if1.ready_o), 64'h0);
        chk("reset.instruc_o", 64'(if1.instruc_o), 64'(NOP));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        valid_i = 1'b0; ready_i = 1'b1; flush_i = 1'b0;
        @(negedge clk);
        chk("release.ready_o", 64'(if1.ready_o), 64'h1);

        foreach (tbl[i]) begin
            step(tbl[i].v, tbl[i].r, tbl[i].f, tbl[i].pc);
            @(negedge clk);
            chk($sformatf("tbl%0d.valid_o", i), 64'(if1.valid_o), 64'(tbl[i].e_valid));
            chk($sformatf("tbl%0d.PC_o", i), 64'(if1.PC_o), 64'(tbl[i].e_pc));
            chk($sformatf("tbl%0d.instruc_o", i), 64'(if1.instruc_o),
                tbl[i].e_valid ? 64'(instr_of(tbl[i].e_pc)) : 64'(NOP));
            chk($sformatf("tbl%0d.occ_o", i), 64'(if1.occ_o), 64'(tbl[i].e_occ));
            chk($sformatf("tbl%0d.ready_o", i), 64'(if1.ready_o), 64'(tbl[i].e_ready));
        end

        // single-register mode: ready_o follows ready_i in the same cycle
        step(1, 1, 0, 32'h500);
        step(1, 0, 0, 32'h504);
        @(negedge clk);
        chk("noskid.ready_o", 64'(if0.ready_o), 64'h0);
        chk("noskid.occ_o", 64'(if0.occ_o), 64'h1);
        chk("noskid.PC_o", 64'(if0.PC_o), 64'h500);
        step(0, 1, 0, 32'h0);
        step(0, 1, 0, 32'h0);
        step(0, 1, 0, 32'h0);

        // asynchronous reset in the middle of a full stall
        step(1, 0, 0, 32'h600);
        step(1, 0, 0, 32'h604);
        step(0, 0, 0, 32'h0);
        @(negedge clk);
        chk("midrst.occ_before", 64'(if1.occ_o), 64'h2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst.valid_o", 64'(if1.valid_o), 64'h0);
        chk("midrst.PC_o", 64'(if1.PC_o), 64'h0);
        chk("midrst.instruc_o", 64'(if1.instruc_o), 64'(NOP));
        chk("midrst.occ_o", 64'(if1.occ_o), 64'h0);
        chk("midrst.ready_o", 64'(if1.ready_o), 64'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        ready_i = 1'b1;
        step(1, 1, 0, 32'h700);
        step(0, 1, 0, 32'h0);
        @(negedge clk);
        chk("postrst.PC_o", 64'(if1.PC_o), 64'h700);
        chk("postrst.occ_o", 64'(if1.occ_o), 64'h1);
        step(0, 1, 0, 32'h0);
        @(negedge clk);
        chk("postrst.valid_o", 64'(if1.valid_o), 64'h0);

        // random traffic against the queue model
        repeat (400) begin
            @(posedge clk);
            #1;
            valid_i = ($urandom_range(0, 3) != 0);
            ready_i = ($urandom_range(0, 2) != 0);
            flush_i = ($urandom_range(0, 9) == 0);
            pc_i    = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
            instr_i = $urandom();
        end
        step(0, 1, 0, 32'h0);
        repeat (3) @(posedge clk);
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ifid_pipe_stage.md
# ifid_pipe_stage

Parametrised IF/ID pipeline stage for the RISC-V core: carries PC and instruction from fetch to decode with a valid/ready handshake, an optional one-entry skid buffer, and synchronous flush. It replaces the write-enable/flush register between the IF and ID stages. Memory and hazard stalls map onto `ready_i`, and branch/jump redirects map onto `flush_i`. Whenever `valid_o` is low, the outputs present a NOP bubble.

## Interface
- `PC_W`, 32, PC width in bits.
- `INSTR_W`, 32, instruction width in bits.
- `SKID_EN`, 1, selects the mode: 1 = two-entry skid buffer with fully registered `ready_o`; 0 = single register with combinational `ready_o`.
- `NOP_INSTR`, 32'h0000_0013, bubble instruction (`addi x0,x0,0`), truncated or zero-extended to `INSTR_W`.
- `clk_i` in 1: single clock, rising edge.
- `rst_n_i` in 1: reset, asynchronous and active-low.
- `flush_i` in 1: synchronous flush (branch mispredict or jump).
- `valid_i` in 1: fetch offers PC/instruction.
- `ready_o` out 1: stage accepts this cycle.
- `PC_i` in PC_W: fetch PC.
- `instruc_i` in INSTR_W: fetched instruction.
- `valid_o` out 1: decode-side entry valid.
- `ready_i` in 1: decode accepts; low means stall.
- `PC_o` out PC_W: head PC; 0 when `valid_o`=0.
- `instruc_o` out INSTR_W: head instruction; `NOP_INSTR` when `valid_o`=0.
- `occ_o` out 2: entries held (0, 1 or 2).

## Operation
- Two storage entries: **main**, which drives the outputs, and **skid**, which exists only when `SKID_EN`=1.
- FSM states: EMPTY (occ 0), FULL (occ 1), SKID (occ 2).
- Handshake terms:
  - `in_fire` = `valid_i` & `ready_o`.
  - `out_fire` = `valid_o` & `ready_i`.
- Transitions when `flush_i`=0:
  - EMPTY: `in_fire` → FULL, main ← input.
  - FULL, `in_fire` & `out_fire` → FULL, main ← input.
  - FULL, `in_fire` & !`out_fire` → SKID, skid ← input (`SKID_EN`=1 only).
  - FULL, !`in_fire` & `out_fire` → EMPTY, main ← bubble (PC 0, `NOP_INSTR`).
  - SKID, `out_fire` → FULL, main ← skid, skid ← bubble.
  - No fire: hold state and data.
- `ready_o`:
  - `SKID_EN`=1: `ready_o` = (state != SKID), registered-state only, no combinational path from `ready_i`.
  - `SKID_EN`=0: `ready_o` = !`valid_o` | `ready_i`. The SKID state is unreachable.
- Flush has highest priority:
  - Next state EMPTY; both entries ← bubble.
  - A same-cycle `in_fire` input is discarded.
  - A same-cycle `out_fire` still counts as consumed by decode.
- Entries are FIFO-ordered; no reordering, duplication or loss except on flush.
- `valid_o` = (state != EMPTY). `occ_o` encodes the state.

## Timing
- Reset (asynchronous assert, released on a clock edge):
  - state EMPTY.
  - `valid_o`=0, `PC_o`=0, `instruc_o`=`NOP_INSTR`, `occ_o`=0.
  - `ready_o`=1 after release. `ready_o` is forced to 0 while `rst_n_i`=0.
- Latency: 1 cycle from `in_fire` to `valid_o`. Throughput is 1 per cycle when `ready_i`=1.
- Stall (`ready_i`=0) with `SKID_EN`=1: one more word is absorbed, then `ready_o` drops in the next cycle.
- Reset asserted mid-operation: all entries are lost immediately, and the outputs take their reset values without waiting for a clock.
- `flush_i` and `rst_n_i` both active: reset dominates.

## Structure
- Shared package `pipe_pkg` holds:
  - state enum `pipe_state_e` (EMPTY, FULL, SKID);
  - `RV_NOP` constant;
  - a bubble-entry struct type {pc, instr}, reused by the ID/EX and EX/MEM successors.
- No sub-module. One FSM plus two entry registers in a single module, generate-gated on `SKID_EN`.

## Test plan
- **Reset:** hold `rst_n_i`=0 with random inputs → `valid_o`=0, `PC_o`=0, `instruc_o`=0x00000013, `ready_o`=0; release → `ready_o`=1.
- **Streaming:** `valid_i`=1 and `ready_i`=1 for 8 cycles, PC 0x100,0x104,… → same sequence on outputs 1 cycle later, `occ_o`=1 throughout.
- **Stall absorb (`SKID_EN`=1):** `ready_i`=0 with PCs 0x200 and 0x204 offered → `occ_o`=2, `ready_o`=0, `PC_o`=0x200 held. Raise `ready_i` → 0x200 then 0x204 out, no loss.
- **Flush in SKID state with `valid_i`=1** (PC 0x300) → next cycle `valid_o`=0, `instruc_o`=NOP, `occ_o`=0; 0x300 never appears.
- **`SKID_EN`=0, `ready_i`=0:** `ready_o`=0 in the same cycle; `occ_o` never exceeds 1.
- **Asynchronous reset pulse mid-stall (`occ_o`=2)** → outputs reset before the next edge; first post-reset input emerges alone.
